// File: rtl/lcd_fifo_ctrl.sv
// Pointer/flag controller that turns an external async-read RAM into a
// first-word-fall-through FIFO for the LCD pixel path.
module lcd_fifo_ctrl #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int LOW_WM  = 8,
   parameter int HIGH_WM = 28
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_write,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty,
   output logic          dma_req,
   output logic          ovf_err,
   output logic          unf_err,
   input  logic          err_clr
);

   localparam logic [AW:0] DEPTH_LVL = (AW+1)'(1 << AW);
   localparam logic [AW:0] LOW_LVL   = (AW+1)'(LOW_WM);
   localparam logic [AW:0] HIGH_LVL  = (AW+1)'(HIGH_WM);

   typedef enum logic {ST_IDLE = 1'b0, ST_REFILL = 1'b1} dma_state_t;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          full_q, empty_q;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          dma_req_q;
   dma_state_t    state_q;
   logic          push, pop;

   // Reset and flush gate the strobes so nothing reaches the RAM in those cycles.
   assign push = wr_valid & ~full_q  & rst_n & ~flush;
   assign pop  = rd_ready & ~empty_q & rst_n & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end
      ovf_d = (ovf_q & ~err_clr) | (wr_valid & full_q);
      unf_d = (unf_q & ~err_clr) | (rd_ready & empty_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         full_q    <= (level_d == DEPTH_LVL);
         empty_q   <= (level_d == '0);
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Hysteresis runs on the next-state level so dma_req moves on the same edge as level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_REFILL;
         dma_req_q <= 1'b1;
      end else if (flush) begin
         state_q   <= ST_REFILL;
         dma_req_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (level_d <= LOW_LVL) begin
                  state_q   <= ST_REFILL;
                  dma_req_q <= 1'b1;
               end
            end
            ST_REFILL: begin
               if (level_d >= HIGH_LVL) begin
                  state_q   <= ST_IDLE;
                  dma_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_REFILL;
               dma_req_q <= 1'b1;
            end
         endcase
      end
   end

   assign wr_ready  = ~full_q;
   assign rd_valid  = ~empty_q;
   assign rd_data   = mem_rdata;
   assign mem_waddr = wr_ptr_q;
   assign mem_wdata = wr_data;
   assign mem_write = push;
   assign mem_raddr = rd_ptr_q;
   assign level     = level_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign dma_req   = dma_req_q;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;

endmodule

// File: tb/tb_lcd_fifo_ctrl.sv
// Directed bench for lcd_fifo_ctrl with a behavioural 32x32 async-read RAM
// and a queue holding the words expected at the FIFO head.
module tb_lcd_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, flush, wr_valid, rd_ready, err_clr;
   logic        wr_ready, rd_valid, mem_write, full, empty, dma_req, ovf_err, unf_err;
   logic [31:0] wr_data, rd_data, mem_wdata, mem_rdata;
   logic [4:0]  mem_waddr, mem_raddr;
   logic [5:0]  level;

   logic [31:0] mem [32];
   logic [31:0] sb [$];
   int          vec_cnt = 0;
   int          err_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_write) mem[mem_waddr] <= mem_wdata;
   assign mem_rdata = mem[mem_raddr];

   lcd_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .level(level), .full(full), .empty(empty), .dma_req(dma_req),
      .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
   );

   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         wr_valid = 1'b1;
         wr_data  = base + 32'(k);
         step();
         sb.push_back(base + 32'(k));
      end
      wr_valid = 1'b0;
   endtask

   task automatic pop_words(input int n);
      for (int k = 0; k < n; k++) begin
         check_vec("pop_valid", 64'(rd_valid), 64'd1);
         check_vec("pop_data", 64'(rd_data), 64'(sb[0]));
         rd_ready = 1'b1;
         step();
         void'(sb.pop_front());
      end
      rd_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      err_clr = 1'b0; wr_data = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      step(); step();
      rst_n = 1'b1;
      check_vec("rst_level", 64'(level), 64'd0);
      check_vec("rst_empty", 64'(empty), 64'd1);
      check_vec("rst_full", 64'(full), 64'd0);
      check_vec("rst_wr_ready", 64'(wr_ready), 64'd1);
      check_vec("rst_rd_valid", 64'(rd_valid), 64'd0);
      check_vec("rst_dma_req", 64'(dma_req), 64'd1);
      check_vec("rst_errs", 64'({ovf_err, unf_err}), 64'd0);

      // Fill 0..31; dma_req drops on the edge level reaches 28.
      for (int i = 0; i < 32; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'(i);
         step();
         sb.push_back(32'(i));
         check_vec("fill_level", 64'(level), 64'(i + 1));
         check_vec("fill_dma", 64'(dma_req), (i + 1 < 28) ? 64'd1 : 64'd0);
      end
      wr_valid = 1'b0;
      check_vec("full_flag", 64'(full), 64'd1);
      check_vec("full_wr_ready", 64'(wr_ready), 64'd0);

      // Overflow attempt.
      wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
      #1 check_vec("ovf_no_write", 64'(mem_write), 64'd0);
      step();
      wr_valid = 1'b0;
      check_vec("ovf_set", 64'(ovf_err), 64'd1);
      check_vec("ovf_level", 64'(level), 64'd32);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_vec("ovf_clr", 64'(ovf_err), 64'd0);

      // Drain 32 -> 0, hold at 9 in IDLE, reassert on reaching 8.
      for (int lvl = 31; lvl >= 0; lvl--) begin
         pop_words(1);
         check_vec("drain_level", 64'(level), 64'(lvl));
         check_vec("drain_dma", 64'(dma_req), (lvl <= 8) ? 64'd1 : 64'd0);
         if (lvl == 9) begin
            for (int h = 0; h < 3; h++) begin
               step();
               check_vec("hold9_dma", 64'(dma_req), 64'd0);
            end
         end
      end
      check_vec("drain_empty", 64'(empty), 64'd1);

      // Push with pop attempt on empty.
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'hA5A5A5A5;
      step();
      wr_valid = 1'b0; rd_ready = 1'b0;
      sb.push_back(32'hA5A5A5A5);
      check_vec("pe_level", 64'(level), 64'd1);
      check_vec("pe_unf", 64'(unf_err), 64'd1);
      check_vec("pe_rd_valid", 64'(rd_valid), 64'd1);
      check_vec("pe_rd_data", 64'(rd_data), 64'h00000000A5A5A5A5);
      pop_words(1);
      check_vec("pe_level0", 64'(level), 64'd0);

      // Level 20 then 50 cycles of push+pop across the 31->0 wrap.
      push_words(20, 32'h100);
      check_vec("wrap_start_level", 64'(level), 64'd20);
      for (int c = 0; c < 50; c++) begin
         check_vec("wrap_data", 64'(rd_data), 64'(sb[0]));
         wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'h200 + 32'(c);
         step();
         sb.push_back(32'h200 + 32'(c));
         void'(sb.pop_front());
         check_vec("wrap_level", 64'(level), 64'd20);
      end
      wr_valid = 1'b0; rd_ready = 1'b0;

      // Reach IDLE at 28, drain to 10, then flush.
      push_words(8, 32'h300);
      check_vec("pre_flush_dma28", 64'(dma_req), 64'd0);
      pop_words(18);
      check_vec("pre_flush_level", 64'(level), 64'd10);
      check_vec("pre_flush_dma", 64'(dma_req), 64'd0);
      flush = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'h12345678;
      #1 check_vec("flush_no_write", 64'(mem_write), 64'd0);
      step();
      flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      sb.delete();
      check_vec("flush_level", 64'(level), 64'd0);
      check_vec("flush_empty", 64'(empty), 64'd1);
      check_vec("flush_dma", 64'(dma_req), 64'd1);
      check_vec("flush_errs", 64'({ovf_err, unf_err}), 64'b01);

      // Full with simultaneous push+pop: only the pop happens.
      push_words(32, 32'h400);
      check_vec("fpp_full", 64'(full), 64'd1);
      check_vec("fpp_head", 64'(rd_data), 64'h400);
      wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'hCAFEF00D;
      #1 check_vec("fpp_no_write", 64'(mem_write), 64'd1 - 64'd1);
      step();
      wr_valid = 1'b0; rd_ready = 1'b0;
      void'(sb.pop_front());
      check_vec("fpp_level", 64'(level), 64'd31);
      pop_words(2);

      // Reset mid-burst.
      wr_valid = 1'b1; wr_data = 32'h55AA55AA; rst_n = 1'b0;
      #1 check_vec("rst_burst_no_write", 64'(mem_write), 64'd0);
      step();
      rst_n = 1'b1; wr_valid = 1'b0;
      sb.delete();
      check_vec("rstb_level", 64'(level), 64'd0);
      check_vec("rstb_dma", 64'(dma_req), 64'd1);
      check_vec("rstb_empty", 64'(empty), 64'd1);
      check_vec("rstb_errs", 64'({ovf_err, unf_err}), 64'd0);

      // Clear and new event in the same cycle: set wins.
      rd_ready = 1'b1; err_clr = 1'b1;
      step();
      rd_ready = 1'b0; err_clr = 1'b0;
      check_vec("set_wins_unf", 64'(unf_err), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
